icache_bk_ctrl: RTL and testbench
=================================

# icache_bk_ctrl

Control and fill engine for the backup direct-mapped instruction cache (8 sets, 256-bit lines). It sits between the fetch stage and the data array. It resolves hit/miss against its own tag/valid store and returns 32-bit instruction words. On a miss it assembles a 256-bit line from a 4-beat 64-bit memory burst, then writes the line into the data array through the array's write/index/datain ports.

## Interface
Parameters:
- BURST_LEN, 4, beats per line fill; BURST_LEN*BEAT_W must equal 256
- BEAT_W, 64, memory beat width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_read  in  1  fetch request; held with cpu_addr stable until cpu_resp
- cpu_addr  in  32  byte address; [31:8] tag, [7:5] index, [4:2] word, [1:0] ignored
- cpu_rdata  out  32  instruction word, valid when cpu_resp=1
- cpu_resp  out  1  one-cycle completion pulse
- mem_read  out  1  burst request, held high for the whole burst
- mem_addr  out  32  line-aligned address {tag,index,5'b0}
- mem_rdata  in  BEAT_W  burst beat data
- mem_resp  in  1  beat valid; beat 0 first, lowest line bits first
- arr_web  out  1  data-array write enable
- arr_index  out  3  data-array set index
- arr_datain  out  256  line to write
- arr_dataout  in  256  combinational read data of set arr_index
- hit_count, miss_count  out  32  present only under ICACHE_PERF_EN

## Operation
- State machine, states CHECK, FILL, WRITE; reset state is CHECK.
- CHECK:
  - arr_index = cpu_addr[7:5].
  - Hit means cpu_read=1, valid[index]=1 and tag[index]==cpu_addr[31:8].
  - On a hit, cpu_resp=1 and cpu_rdata = arr_dataout[32*cpu_addr[4:2] +: 32] in the same cycle.
  - On a miss with cpu_read=1, latch tag and index, clear the beat counter, and go to FILL.
- FILL:
  - mem_read=1; mem_addr comes from the latched tag and index; arr_index = latched index.
  - Each mem_resp stores mem_rdata into line buffer slot beat_cnt, then beat_cnt increments.
  - On the BURST_LEN-th beat, go to WRITE.
- WRITE:
  - mem_read=0; arr_web=1; arr_datain = line buffer; arr_index = latched index.
  - Set tag[idx] to the latched tag and valid[idx] to 1.
  - Return to CHECK. The held request then hits.
- Boundary rules:
  - mem_resp outside FILL is ignored.
  - If cpu_read drops during FILL, the fill still completes and the line is installed; no cpu_resp is produced.
  - A conflict miss overwrites the resident line; there is no write-back (read-only cache).
  - A changed cpu_addr during FILL is a protocol violation; behaviour is unspecified.
- Reset: valid[7:0]=0, beat_cnt=0, line buffer=0.
  - All outputs are 0 during and after reset: cpu_resp, cpu_rdata, mem_read, mem_addr, arr_web, arr_datain, arr_index (0 while cpu_addr=0).
  - Reset during FILL abandons the burst: mem_read is low the next cycle and no array write occurs.

## Timing
- Hit latency: 0 cycles; cpu_resp is combinational in the request cycle.
- Miss: 1 CHECK cycle, then FILL until the last mem_resp, then 1 WRITE cycle, then the hit in CHECK.
  - With single-cycle beats, a miss takes 1+4+1 cycles, and cpu_resp arrives in the 7th cycle.
- mem_read rises the cycle after the miss is detected and falls the cycle after the last beat.
- arr_web is high for exactly one cycle per fill.
- Tag and valid updates land at the WRITE clock edge, so they are visible in the following CHECK.

## Configuration
- ICACHE_PERF_EN defined:
  - hit_count and miss_count ports exist, reset to 0, and saturate at 32'hFFFFFFFF.
  - miss_count increments on each CHECK->FILL transition.
  - hit_count increments on each cpu_resp for a request that did not incur a fill.
- ICACHE_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package icache_bk_pkg holds:
  - the state enum (CHECK, FILL, WRITE);
  - constants TAG_W=24, IDX_W=3, OFF_W=5, LINE_W=256, NUM_SETS=8.
- Sub-module icache_bk_tag_array holds 8x24-bit tags and 8 valid bits.
  - Combinational read, synchronous write, synchronous reset of the valid bits.

## Test plan
- Cold miss: after reset, read 0x0000_0104, burst beats 0x11..,0x22..,0x33..,0x44.. -> mem_addr=0x0000_0100, arr_web pulse at index 0, cpu_resp 7 cycles after the request with the word-1 slice of beat 0.
- Hit: re-read 0x0000_011C -> cpu_resp in the same cycle, no mem_read, data = upper word of beat 3.
- Conflict: read 0x0000_1100 (index 0, new tag) -> refill, tag replaced; a later read of 0x0000_0100 misses again.
- Stray mem_resp: pulse mem_resp in CHECK -> no state change, no array write.
- Reset mid-fill: assert rst after 2 beats -> mem_read=0 next cycle, no arr_web, read of the same address misses.
- Perf (ICACHE_PERF_EN): 1 cold miss then 3 hits -> miss_count=1, hit_count=3.

Source files
------------

// File: rtl/icache_bk_pkg.sv
// icache_bk_pkg: shared types and geometry for the backup instruction cache.
//   state_t  - controller states CHECK / FILL / WRITE
//   TAG_W, IDX_W, OFF_W, LINE_W, NUM_SETS - address split and array geometry
package icache_bk_pkg;

  localparam int unsigned TAG_W    = 24;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned OFF_W    = 5;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned NUM_SETS = 8;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/icache_bk_tag_array.sv
// icache_bk_tag_array: 8 x 24-bit tag store with one valid bit per set.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears valid bits only)
//   i_rd_idx     - combinational read index
//   o_rd_tag     - tag stored at i_rd_idx
//   o_rd_valid   - valid bit at i_rd_idx
//   i_we         - write enable: installs i_wr_tag at i_wr_idx and sets valid
//   i_wr_idx     - write index
//   i_wr_tag     - tag to install
module icache_bk_tag_array
  import icache_bk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic             o_rd_valid,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag
);

  logic [TAG_W-1:0]    r_tag [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tags need no reset: an entry is only consulted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_we && !rst) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/icache_bk_ctrl.sv
// icache_bk_ctrl: control and fill engine for the backup direct-mapped
// instruction cache (8 sets, 256-bit lines, read-only, no write-back).
// Optional feature macro: ICACHE_PERF_EN adds saturating hit/miss counters.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   cpu_read, cpu_addr    - fetch request, held until cpu_resp
//   cpu_rdata, cpu_resp   - 32-bit instruction word and one-cycle completion
//   mem_read, mem_addr    - line burst request (held for the burst), line address
//   mem_rdata, mem_resp   - burst beat data and beat valid (beat 0 first)
//   arr_web, arr_index    - data-array write enable and set index
//   arr_datain            - line written to the data array
//   arr_dataout           - combinational read data of set arr_index
//   hit_count, miss_count - performance counters (ICACHE_PERF_EN only)
module icache_bk_ctrl
  import icache_bk_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [31:0]       cpu_addr,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_resp,
  output logic              mem_read,
  output logic [31:0]       mem_addr,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arr_web,
  output logic [IDX_W-1:0]  arr_index,
  output logic [LINE_W-1:0] arr_datain,
  input  logic [LINE_W-1:0] arr_dataout
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t r_state;
  state_t w_next;

  logic [TAG_W-1:0]                r_tag;
  logic [IDX_W-1:0]                r_idx;
  logic [CNT_W-1:0]                r_beat_cnt;
  logic [BURST_LEN-1:0][BEAT_W-1:0] r_line;

  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_valid;
  logic             w_hit;
  logic             w_miss;
  logic             w_tag_we;
  logic [7:0]       w_word_lsb;
  logic [31:0]      w_word;

  icache_bk_tag_array u_tag_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (cpu_addr[7:5]),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .i_we       (w_tag_we),
    .i_wr_idx   (r_idx),
    .i_wr_tag   (r_tag)
  );

  assign w_word_lsb = {cpu_addr[4:2], 5'b00000};
  assign w_word     = arr_dataout[w_word_lsb +: 32];
  assign w_hit      = (r_state == CHECK) && !rst && cpu_read && w_rd_valid &&
                      (w_rd_tag == cpu_addr[31:8]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CHECK;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are forced low while rst is high so nothing leaks during reset.
  always_comb begin
    w_next     = r_state;
    cpu_resp   = 1'b0;
    cpu_rdata  = '0;
    mem_read   = 1'b0;
    mem_addr   = '0;
    arr_web    = 1'b0;
    arr_index  = '0;
    arr_datain = '0;
    w_miss     = 1'b0;
    w_tag_we   = 1'b0;
    if (!rst) begin
      case (r_state)
        CHECK: begin
          arr_index = cpu_addr[7:5];
          if (w_hit) begin
            cpu_resp  = 1'b1;
            cpu_rdata = w_word;
          end else if (cpu_read) begin
            w_miss = 1'b1;
            w_next = FILL;
          end
        end
        FILL: begin
          mem_read  = 1'b1;
          mem_addr  = {r_tag, r_idx, {OFF_W{1'b0}}};
          arr_index = r_idx;
          if (mem_resp && (r_beat_cnt == LAST_BEAT)) begin
            w_next = WRITE;
          end
        end
        WRITE: begin
          arr_web    = 1'b1;
          arr_datain = r_line;
          arr_index  = r_idx;
          w_tag_we   = 1'b1;
          w_next     = CHECK;
        end
        default: w_next = CHECK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag      <= '0;
      r_idx      <= '0;
      r_beat_cnt <= '0;
      r_line     <= '0;
    end else begin
      if (w_miss) begin
        r_tag      <= cpu_addr[31:8];
        r_idx      <= cpu_addr[7:5];
        r_beat_cnt <= '0;
      end
      if ((r_state == FILL) && mem_resp) begin
        r_line[r_beat_cnt] <= mem_rdata;
        r_beat_cnt         <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

`ifdef ICACHE_PERF_EN
  // r_held tracks whether the request that started a fill stayed asserted
  // through FILL/WRITE; its completion in the following CHECK is then the
  // fill's own response and is not a hit.
  logic r_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      r_held     <= 1'b0;
    end else begin
      if (w_miss) begin
        r_held <= 1'b1;
      end else if ((r_state == CHECK) || !cpu_read) begin
        r_held <= 1'b0;
      end
      if (w_miss && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
      if (cpu_resp && !r_held && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_bk_ctrl.sv
module tb_icache_bk_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_read = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_resp;
  logic         mem_read;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_rdata = '0;
  logic         mem_resp = 1'b0;
  logic         arr_web;
  logic [2:0]   arr_index;
  logic [255:0] arr_datain;
  logic [255:0] arr_dataout;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0]  beats [4];
  logic [255:0] tb_arr [8];

  always #5 clk = ~clk;

  icache_bk_ctrl #(.BURST_LEN(4), .BEAT_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_read    (cpu_read),
    .cpu_addr    (cpu_addr),
    .cpu_rdata   (cpu_rdata),
    .cpu_resp    (cpu_resp),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .arr_web     (arr_web),
    .arr_index   (arr_index),
    .arr_datain  (arr_datain),
    .arr_dataout (arr_dataout)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  // Data array stub: combinational read, write on clock edge.
  assign arr_dataout = tb_arr[arr_index];
  always @(posedge clk) if (arr_web) tb_arr[arr_index] <= arr_datain;

  task automatic set_beats(input logic [63:0] b0, b1, b2, b3);
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1; cpu_read = 1'b0; cpu_addr = '0; mem_resp = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issues one request and serves the burst; reports what was observed.
  task automatic fill_line(input logic [31:0] addr, output int cyc, output int webs,
                           output logic [2:0] widx, output int mrc,
                           output logic [31:0] maddr, output logic got,
                           output logic [31:0] rdata);
    int k;
    k = 0; cyc = 1; webs = 0; widx = '0; mrc = 0; maddr = '0; got = 1'b0; rdata = '0;
    cpu_addr = addr; cpu_read = 1'b1;
    #1;
    if (cpu_resp) begin got = 1'b1; rdata = cpu_rdata; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1; cyc++;
      if (arr_web) begin webs++; widx = arr_index; end
      if (mem_read) begin mrc++; maddr = mem_addr; end
      if (cpu_resp) begin got = 1'b1; rdata = cpu_rdata; end
      if (mem_read && k < 4) begin mem_rdata = beats[k]; mem_resp = 1'b1; k++; end
      else mem_resp = 1'b0;
    end
    cpu_read = 1'b0; mem_resp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cpu_resp !== 1'b0) begin errors++; $display("FAIL rst_cpu_resp: got %b expected 0", cpu_resp); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h expected 0", cpu_rdata); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (arr_web !== 1'b0) begin errors++; $display("FAIL rst_arr_web: got %b expected 0", arr_web); end
    checks++; if (arr_index !== 3'd0) begin errors++; $display("FAIL rst_arr_index: got %0d expected 0", arr_index); end
    checks++; if (arr_datain !== 256'h0) begin errors++; $display("FAIL rst_arr_datain: got %h expected 0", arr_datain); end
    @(posedge clk); #1 rst = 1'b0; #1;
    checks++; if ({cpu_resp, mem_read, arr_web} !== 3'b000) begin errors++; $display("FAIL post_rst_outputs: got %b expected 000", {cpu_resp, mem_read, arr_web}); end
  endtask

  task automatic test_cold_miss();
    int cyc, webs, mrc; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    set_beats(64'h1111_0001_1111_0000, 64'h2222_0003_2222_0002,
              64'h3333_0005_3333_0004, 64'h4444_0007_4444_0006);
    fill_line(32'h0000_0104, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL cold_resp: got %b expected 1", got); end
    checks++; if (cyc != 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", cyc); end
    checks++; if (maddr !== 32'h0000_0100) begin errors++; $display("FAIL cold_mem_addr: got %h expected 00000100", maddr); end
    checks++; if (mrc != 4) begin errors++; $display("FAIL cold_mem_read_cycles: got %0d expected 4", mrc); end
    checks++; if (webs != 1 || widx !== 3'd0) begin errors++; $display("FAIL cold_arr_write: got %0d writes idx %0d expected 1 idx 0", webs, widx); end
    checks++; if (rd !== 32'h1111_0001) begin errors++; $display("FAIL cold_rdata: got %h expected 11110001", rd); end
    checks++;
    if (tb_arr[0] !== 256'h4444_0007_4444_0006_3333_0005_3333_0004_2222_0003_2222_0002_1111_0001_1111_0000) begin
      errors++; $display("FAIL cold_line: got %h", tb_arr[0]);
    end
  endtask

  task automatic test_hit();
    int cyc, webs, mrc; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    fill_line(32'h0000_011C, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (got !== 1'b1 || cyc != 1) begin errors++; $display("FAIL hit_latency: got resp %b cycle %0d expected 1 cycle 1", got, cyc); end
    checks++; if (mrc != 0 || webs != 0) begin errors++; $display("FAIL hit_no_fill: got %0d mem_read %0d writes expected 0 0", mrc, webs); end
    checks++; if (rd !== 32'h4444_0007) begin errors++; $display("FAIL hit_rdata_w7: got %h expected 44440007", rd); end
    fill_line(32'h0000_0108, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (rd !== 32'h2222_0002 || cyc != 1) begin errors++; $display("FAIL hit_rdata_w2: got %h cycle %0d expected 22220002 cycle 1", rd, cyc); end
  endtask

  task automatic test_conflict();
    int cyc, webs, mrc; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    set_beats(64'hAAAA_0001_AAAA_0000, 64'hBBBB_0003_BBBB_0002,
              64'hCCCC_0005_CCCC_0004, 64'hDDDD_0007_DDDD_0006);
    fill_line(32'h0000_1100, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (cyc != 7 || maddr !== 32'h0000_1100) begin errors++; $display("FAIL conflict_fill: got cycle %0d addr %h expected 7 00001100", cyc, maddr); end
    checks++; if (rd !== 32'hAAAA_0000 || widx !== 3'd0) begin errors++; $display("FAIL conflict_rdata: got %h idx %0d expected aaaa0000 idx 0", rd, widx); end
    set_beats(64'h1111_0001_1111_0000, 64'h2222_0003_2222_0002,
              64'h3333_0005_3333_0004, 64'h4444_0007_4444_0006);
    fill_line(32'h0000_0100, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (cyc != 7 || webs != 1) begin errors++; $display("FAIL conflict_remiss: got cycle %0d writes %0d expected 7 1", cyc, webs); end
    checks++; if (rd !== 32'h1111_0000) begin errors++; $display("FAIL conflict_remiss_rdata: got %h expected 11110000", rd); end
  endtask

  task automatic test_index7();
    int cyc, webs, mrc; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    set_beats(64'h7777_0001_7777_0000, 64'h7777_0003_7777_0002,
              64'h7777_0005_7777_0004, 64'h7777_0007_7777_0006);
    fill_line(32'hFFFF_FFE4, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (maddr !== 32'hFFFF_FFE0 || widx !== 3'd7) begin errors++; $display("FAIL idx7_addr: got %h idx %0d expected ffffffe0 idx 7", maddr, widx); end
    checks++; if (rd !== 32'h7777_0001 || cyc != 7) begin errors++; $display("FAIL idx7_rdata: got %h cycle %0d expected 77770001 cycle 7", rd, cyc); end
  endtask

  task automatic test_stray_resp();
    int cyc, webs, mrc, bad; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    bad = 0;
    cpu_read = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; mem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (arr_web || mem_read || cpu_resp) bad++;
    end
    mem_resp = 1'b0;
    @(posedge clk); #1;
    if (arr_web || mem_read) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stray_no_action: got %0d active cycles expected 0", bad); end
    fill_line(32'h0000_0104, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (cyc != 1 || rd !== 32'h1111_0001) begin errors++; $display("FAIL stray_hit_after: got cycle %0d data %h expected 1 11110001", cyc, rd); end
  endtask

  task automatic test_cpu_drop();
    int cyc, webs, mrc, k, resp; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    set_beats(64'hEEEE_0001_EEEE_0000, 64'hEEEE_0003_EEEE_0002,
              64'hEEEE_0005_EEEE_0004, 64'hEEEE_0007_EEEE_0006);
    k = 0; resp = 0; webs = 0;
    cpu_addr = 32'h0000_2040; cpu_read = 1'b1; #1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (cpu_resp) resp++;
      if (arr_web) webs++;
      if (mem_read && k < 4) begin
        mem_rdata = beats[k]; mem_resp = 1'b1; k++;
        if (k == 2) cpu_read = 1'b0;
      end else mem_resp = 1'b0;
    end
    checks++; if (resp != 0) begin errors++; $display("FAIL drop_no_resp: got %0d responses expected 0", resp); end
    checks++; if (webs != 1) begin errors++; $display("FAIL drop_installed: got %0d writes expected 1", webs); end
    fill_line(32'h0000_2040, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (cyc != 1 || rd !== 32'hEEEE_0000) begin errors++; $display("FAIL drop_hit_after: got cycle %0d data %h expected 1 eeee0000", cyc, rd); end
  endtask

  task automatic test_reset_midfill();
    int cyc, webs, mrc, k, bad; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    set_beats(64'h5555_0001_5555_0000, 64'h5555_0003_5555_0002,
              64'h5555_0005_5555_0004, 64'h5555_0007_5555_0006);
    k = 0; bad = 0;
    cpu_addr = 32'h0000_3060; cpu_read = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (mem_read && k < 2) begin mem_rdata = beats[k]; mem_resp = 1'b1; k++; end
    end
    @(posedge clk); #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL midfill_active: got mem_read %b expected 1", mem_read); end
    rst = 1'b1; cpu_read = 1'b0; mem_rdata = beats[2];
    @(posedge clk); #1 rst = 1'b0; #1;
    checks++; if (mem_read !== 1'b0 || arr_web !== 1'b0) begin errors++; $display("FAIL midfill_abandon: got mem_read %b arr_web %b expected 0 0", mem_read, arr_web); end
    mem_rdata = beats[3];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (arr_web || mem_read) bad++;
    end
    mem_resp = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL midfill_no_write: got %0d active cycles expected 0", bad); end
    fill_line(32'h0000_3060, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (cyc != 7 || widx !== 3'd3) begin errors++; $display("FAIL midfill_remiss: got cycle %0d idx %0d expected 7 3", cyc, widx); end
    checks++; if (rd !== 32'h5555_0000) begin errors++; $display("FAIL midfill_rdata: got %h expected 55550000", rd); end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    int cyc, webs, mrc; logic [2:0] widx; logic [31:0] maddr, rd; logic got;
    apply_reset(2);
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL perf_reset: got hit %0d miss %0d expected 0 0", hit_count, miss_count); end
    set_beats(64'h9999_0001_9999_0000, 64'h9999_0003_9999_0002,
              64'h9999_0005_9999_0004, 64'h9999_0007_9999_0006);
    fill_line(32'h0000_3060, cyc, webs, widx, mrc, maddr, got, rd);
    fill_line(32'h0000_3064, cyc, webs, widx, mrc, maddr, got, rd);
    fill_line(32'h0000_307C, cyc, webs, widx, mrc, maddr, got, rd);
    fill_line(32'h0000_3068, cyc, webs, widx, mrc, maddr, got, rd);
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL perf_miss: got %0d expected 1", miss_count); end
    checks++; if (hit_count !== 32'd3) begin errors++; $display("FAIL perf_hit: got %0d expected 3", hit_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_index7();
    test_stray_resp();
    test_cpu_drop();
    test_reset_midfill();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
